counter_sequencer: RTL

Control block for the WIDTH-bit binary counter datapath: it starts, pauses, stops and terminates a count against a programmable limit. It runs in one-shot or periodic (auto-reload) mode and reports terminal count and completion to the surrounding lab top level. The counter register itself is instantiated inside this block and sequenced by its FSM.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_core.sv | 45 ++++
 rtl/counter_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter sequencer slice.
//   state_e       - sequencer FSM states (IDLE, RUN, HOLD, DONE)
//   MODE_ONESHOT  - Mode value for a single count followed by Done
//   MODE_PERIODIC - Mode value for auto-reload counting
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit binary counter register.
// Ports:
//   Clk   in  - rising-edge clock
//   Rst_n in  - asynchronous active-low reset (Count -> 0)
//   Clr   in  - synchronous clear, takes priority over En
//   En    in  - increment enable (modulo 2^WIDTH)
//   Count out - registered counter value
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clr,
  input  logic             En,
  output logic [WIDTH-1:0] Count
);
  import counter_pkg::*;

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next-count selection: clear beats increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (Clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (En) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule : counter_core

// File: rtl/counter_sequencer.sv
// counter_sequencer: FSM that starts, pauses, stops and terminates a count
// against a limit latched at Start, in one-shot or periodic mode.
// Ports:
//   Clk, Rst_n  - clock and asynchronous active-low reset
//   Start       - begin a count (honoured only in IDLE)
//   Stop        - abort the count (highest priority)
//   Pause       - level-sensitive freeze of Count
//   Mode        - 0 one-shot, 1 periodic (latched at Start)
//   Limit       - terminal count value (latched at Start)
//   Count       - current counter value
//   Busy        - high in every state except IDLE
//   Tick        - pulse in the terminal-count cycle
//   Done        - pulse on one-shot completion
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Tick,
  output logic             Done
);
  import counter_pkg::*;

  state_e           state_d, state_q;
  logic [WIDTH-1:0] limit_d, limit_q;
  logic             mode_d, mode_q;
  logic             clr_s;
  logic             en_s;
  logic             at_limit_s;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Clr   (clr_s),
    .En    (en_s),
    .Count (Count)
  );

  assign at_limit_s = (Count == limit_q);

  // Next-state, latched-parameter and counter-control decode.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (Start) begin
          limit_d = Limit;
          mode_d  = Mode;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          clr_s   = 1'b1;
          state_d = ST_IDLE;
        end else if (Pause) begin
          state_d = ST_HOLD;
        end else if (at_limit_s) begin
          clr_s   = 1'b1;
          state_d = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_DONE;
        end else begin
          en_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Stop) begin
          clr_s   = 1'b1;
          state_d = ST_IDLE;
        end else if (!Pause) begin
          // Back to RUN with the held value; the increment happens from RUN.
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: begin
        clr_s   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        clr_s   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched limit/mode registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      limit_q <= {WIDTH{1'b0}};
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
    end
  end

  // Tick depends on live Stop/Pause so an abort or freeze suppresses it
  // in the same cycle.
  assign Busy = (state_q != ST_IDLE);
  assign Tick = (state_q == ST_RUN) && at_limit_s && !Stop && !Pause;
  assign Done = (state_q == ST_DONE);

endmodule : counter_sequencer
